// File: rtl/modulador_pwm_multi.sv
// rtl/modulador_pwm_multi.sv - N-channel carrier-based PWM modulator with dead-time gate pairs
//
// Purpose:
//   Compares each channel's signed reference against a phase-interleaved
//   triangular carrier and drives a complementary {high, low} gate pair.
//   Each pair passes through a dead-time FSM so that both gates are never on
//   at the same time. References go through shadow registers that are only
//   loaded at the carrier period start, so a reference update never produces
//   a runt pulse in the middle of a period.
//
// Ports:
//   clk   in   1        system clock
//   rst   in   1        synchronous active-high reset
//   en    in   1        output enable, 0 forces every gate off
//   mod   in   NCH*DW   signed references, channel k at mod[k*DW +: DW]
//   out   out  2*NCH    gate pairs, out[2k+1] high side k, out[2k] low side k
//   sync  out  1        one-cycle pulse at the start of each carrier period

module modulador_pwm_multi #(
    parameter int DW    = 8,
    parameter int NCH   = 3,
    parameter int DEAD  = 2,
    parameter int PRESC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NCH*DW-1:0] mod,
    output logic [2*NCH-1:0]  out,
    output logic              sync
);

    localparam int PW  = DW + 1;
    localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CW  = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    // Phase spacing between adjacent channels
    localparam int STEP = (2 ** PW) / NCH;

    typedef enum logic [1:0] {
        ST_DT = 2'd0,
        ST_HI = 2'd1,
        ST_LO = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Prescaler and master phase counter
    // ------------------------------------------------------------------
    logic [PSW-1:0] presc;
    logic [PW-1:0]  ph;
    logic           tick;
    logic           start;

    // A tick is pending whenever the prescaler sits at zero; this makes the
    // very first cycle after reset a period start.
    assign tick  = (presc == '0);
    assign start = tick && (ph == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (presc == PSW'(PRESC - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph <= '0;
        end else if (tick) begin
            ph <= ph + 1'b1;
        end
    end

    // Gated with rst so the pulse stays low while reset is held, even though
    // the counters already sit at the period-start value.
    assign sync = start && !rst;

    // ------------------------------------------------------------------
    // Per-channel carrier, shadow, comparator and dead-time FSM
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [PW-1:0] KOFS = PW'(k * STEP);

        logic [PW-1:0] ph_k;
        logic [DW-1:0] carrier;
        logic [DW-1:0] sh;
        logic          cmd;
        state_t        st_q;
        state_t        st_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [1:0]    pair_q;
        logic [1:0]    pair_d;

        assign ph_k = ph + KOFS;

        // Upper half of the phase counts down, giving a symmetric triangle
        assign carrier = ph_k[DW] ? ~ph_k[DW-1:0] : ph_k[DW-1:0];

        // Shadow holds the reference in offset binary (MSB inverted) so the
        // comparison against the unsigned carrier is a plain magnitude test.
        always_ff @(posedge clk) begin
            if (rst) begin
                sh <= {1'b1, {(DW-1){1'b0}}};
            end else if (start) begin
                sh <= {~mod[k*DW + DW - 1], mod[k*DW +: DW-1]};
            end
        end

        // Uses the shadow value of the current cycle, so a load in the same
        // cycle only affects the command one cycle later.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmd <= 1'b0;
            end else begin
                cmd <= (sh > carrier);
            end
        end

        // State register; the gate pair is registered alongside the state so
        // the outputs come straight from flops.
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q   <= ST_DT;
                cnt_q  <= CW'(DEAD);
                pair_q <= 2'b00;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                pair_q <= pair_d;
            end
        end

        // Next-state logic. The dead-time exit target is taken from cmd at
        // the moment of exit, so a command pulse shorter than the dead time
        // is swallowed instead of producing a sliver on the other side.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            if (!en) begin
                st_d  = ST_DT;
                cnt_d = CW'(DEAD);
            end else begin
                case (st_q)
                    ST_HI: begin
                        if (!cmd) begin
                            if (DEAD == 0) begin
                                st_d = ST_LO;
                            end else begin
                                st_d  = ST_DT;
                                cnt_d = CW'(DEAD);
                            end
                        end
                    end
                    ST_LO: begin
                        if (cmd) begin
                            if (DEAD == 0) begin
                                st_d = ST_HI;
                            end else begin
                                st_d  = ST_DT;
                                cnt_d = CW'(DEAD);
                            end
                        end
                    end
                    default: begin
                        // The cycle holding a count of 1 is the last dead
                        // cycle; a count of 0 only occurs with no dead time.
                        if (cnt_q <= CW'(1)) begin
                            st_d  = cmd ? ST_HI : ST_LO;
                            cnt_d = CW'(DEAD);
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end

        // Output decode from the next state; 2'b11 is not reachable
        always_comb begin
            pair_d = 2'b00;
            case (st_d)
                ST_HI:   pair_d = 2'b10;
                ST_LO:   pair_d = 2'b01;
                default: pair_d = 2'b00;
            endcase
        end

        assign out[2*k +: 2] = pair_q;
    end

endmodule

// File: tb/tb_modulador_pwm_multi.sv
// tb/tb_modulador_pwm_multi.sv - self-checking bench for modulador_pwm_multi

module tb_modulador_pwm_multi;

    localparam int DW    = 8;
    localparam int NCH   = 3;
    localparam int DEAD  = 2;
    localparam int PRESC = 1;
    localparam int PH    = 2 ** (DW + 1);
    localparam int TOP   = 2 ** DW;
    localparam int HALF  = 2 ** (DW - 1);
    localparam int PER   = PRESC * PH;
    localparam int OFS   = PH / NCH;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [NCH*DW-1:0] mod;
    logic [2*NCH-1:0]  out;
    logic              sync;

    always #5 clk = ~clk;

    modulador_pwm_multi #(
        .DW(DW), .NCH(NCH), .DEAD(DEAD), .PRESC(PRESC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mod(mod), .out(out), .sync(sync)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_sync = -1;
    bit armed = 1'b0;

    logic [2*NCH-1:0] s_out;
    logic             s_sync;

    // Reference model: phase, shadow levels, command and driven side per leg
    int m_ph, m_presc;
    int m_sh   [NCH];
    bit m_cmd  [NCH];
    int m_side [NCH];   // 0 none, 1 high, 2 low
    int m_gap  [NCH];   // dead cycles already spent

    int hi [NCH];
    int lo [NCH];
    int zz [NCH];
    int rise [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int carrier_of(input int p, input int k);
        int pk;
        pk = (p + k * OFS) % PH;
        return (pk >= TOP) ? (PH - 1 - pk) : pk;
    endfunction

    function automatic int chan_mod(input int k);
        logic signed [DW-1:0] v;
        v = mod[k*DW +: DW];
        return int'(v);
    endfunction

    function automatic logic [2*NCH-1:0] exp_out();
        logic [2*NCH-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) begin
            if (m_side[k] == 1) v[2*k +: 2] = 2'b10;
            else if (m_side[k] == 2) v[2*k +: 2] = 2'b01;
        end
        return v;
    endfunction

    function automatic logic exp_sync();
        return (rst == 1'b0) && (m_presc == 0) && (m_ph == 0);
    endfunction

    task automatic model_step();
        bit tk, st, c;
        if (rst) begin
            m_ph = 0;
            m_presc = 0;
            for (int k = 0; k < NCH; k++) begin
                m_sh[k] = HALF;
                m_cmd[k] = 1'b0;
                m_side[k] = 0;
                m_gap[k] = 0;
            end
        end else begin
            tk = (m_presc == 0);
            st = tk && (m_ph == 0);
            for (int k = 0; k < NCH; k++) begin
                c = m_cmd[k];
                m_cmd[k] = (m_sh[k] > carrier_of(m_ph, k));
                if (st) m_sh[k] = chan_mod(k) + HALF;
                if (!en) begin
                    m_side[k] = 0;
                    m_gap[k] = 0;
                end else if (m_side[k] == 1 && !c) begin
                    m_side[k] = (DEAD == 0) ? 2 : 0;
                    m_gap[k] = 0;
                end else if (m_side[k] == 2 && c) begin
                    m_side[k] = (DEAD == 0) ? 1 : 0;
                    m_gap[k] = 0;
                end else if (m_side[k] == 0) begin
                    if (m_gap[k] + 1 >= DEAD) m_side[k] = c ? 1 : 2;
                    else m_gap[k]++;
                end
            end
            if (tk) m_ph = (m_ph + 1) % PH;
            m_presc = (m_presc + 1) % PRESC;
        end
    endtask

    // One clock: sample and check mid-cycle, advance the model, step past the edge
    task automatic tick();
        @(negedge clk);
        s_out  = out;
        s_sync = sync;
        if (armed) begin
            chk("out_pairs", 32'(out), 32'(exp_out()));
            chk("sync", 32'(sync), 32'(exp_sync()));
            for (int k = 0; k < NCH; k++)
                chk("no_overlap", 32'(out[2*k+1] & out[2*k]), 32'd0);
            if (rst) begin
                last_sync = -1;
            end else if (sync === 1'b1) begin
                if (last_sync >= 0) chk("sync_period", cyc - last_sync, PER);
                last_sync = cyc;
            end
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        armed = 1'b1;
    endtask

    task automatic wait_sync();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (s_sync !== 1'b1 && n < PER + 8);
        chk("wait_sync", 32'(s_sync), 32'd1);
    endtask

    task automatic run_period(input int chg_at, input logic [DW-1:0] chg_val);
        logic [1:0] prev [NCH];
        logic [1:0] pr;
        for (int k = 0; k < NCH; k++) begin
            hi[k] = 0; lo[k] = 0; zz[k] = 0; rise[k] = -1;
            prev[k] = s_out[2*k +: 2];
        end
        for (int i = 0; i < PER; i++) begin
            if (i == chg_at) mod[DW-1:0] = chg_val;
            tick();
            for (int k = 0; k < NCH; k++) begin
                pr = s_out[2*k +: 2];
                if (pr == 2'b10) hi[k]++;
                else if (pr == 2'b01) lo[k]++;
                else if (pr == 2'b00) zz[k]++;
                if (pr == 2'b10 && prev[k] != 2'b10 && rise[k] < 0) rise[k] = i;
                prev[k] = pr;
            end
        end
    endtask

    initial begin
        int u;
        rst = 1'b1;
        en  = 1'b0;
        mod = '0;

        // Reset and first sync
        tick();
        tick();
        chk("rst_out", 32'(s_out), 32'd0);
        chk("rst_sync", 32'(s_sync), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("sync_after_release", 32'(s_sync), 32'd1);

        // 50% on all legs, dead-time gaps and interleaving
        wait_sync();
        repeat (8) tick();
        run_period(-1, '0);
        u = HALF;
        for (int k = 0; k < NCH; k++) begin
            chk("half_hi", hi[k], 2 * u - DEAD);
            chk("half_lo", lo[k], PER - 2 * u - DEAD);
            chk("half_gap", zz[k], 2 * DEAD);
        end
        for (int k = 1; k < NCH; k++)
            chk("phase_shift", ((rise[0] - rise[k]) % PER + PER) % PER, k * OFS);

        // Mid-period update takes effect only from the next period
        wait_sync();
        repeat (8) tick();
        run_period(200, 8'd60);
        chk("glitch_same_hi", hi[0], 2 * HALF - DEAD);
        chk("glitch_same_lo", lo[0], PER - 2 * HALF - DEAD);
        run_period(-1, '0);
        u = 60 + HALF;
        chk("mod60_hi", hi[0], 2 * u - DEAD);
        chk("mod60_lo", lo[0], PER - 2 * u - DEAD);

        // Extremes
        mod[DW-1:0] = 8'h80;
        wait_sync();
        repeat (8) tick();
        run_period(-1, '0);
        chk("min_hi", hi[0], 0);
        chk("min_lo", lo[0], PER);
        mod[DW-1:0] = 8'h7f;
        wait_sync();
        repeat (8) tick();
        run_period(-1, '0);
        u = HALF - 1 + HALF;
        chk("max_hi", hi[0], PER - (PER - 2 * u));
        chk("max_lo", lo[0], 0);
        chk("max_notch", zz[0], PER - 2 * u);

        // Enable drop while leg 0 is high
        mod[DW-1:0] = 8'h00;
        wait_sync();
        repeat (8) tick();
        chk("en_pre_hi", 32'(s_out[1:0]), 32'd2);
        en = 1'b0;
        tick();
        tick();
        chk("en_off_next", 32'(s_out[1:0]), 32'd0);
        repeat (28) tick();
        chk("en_off_all", 32'(s_out), 32'd0);
        en = 1'b1;
        tick();
        chk("en_back_dt0", 32'(s_out[1:0]), 32'd0);
        tick();
        chk("en_back_dt1", 32'(s_out[1:0]), 32'd0);
        tick();
        chk("en_back_hi", 32'(s_out[1:0]), 32'd2);

        // Reset mid-period with mod0 = 60
        mod[DW-1:0] = 8'd60;
        wait_sync();
        repeat (100) tick();
        rst = 1'b1;
        tick();
        chk("midrst_sync_low", 32'(s_sync), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_out", 32'(s_out), 32'd0);
        chk("midrst_sync", 32'(s_sync), 32'd1);
        repeat (8) tick();
        run_period(-1, '0);
        u = 60 + HALF;
        chk("midrst_hi", hi[0], 2 * u - DEAD);
        chk("midrst_lo", lo[0], PER - 2 * u - DEAD);

        // Randomised references, enables and one reset against the model
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < NCH; k++) mod[k*DW +: DW] = DW'($urandom);
            en = ($urandom_range(0, 5) != 0);
            if (r == 5) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat ($urandom_range(40, 400)) tick();
        end
        en = 1'b1;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
